cla_word_sequencer: RTL and testbench
=====================================

# cla_word_sequencer

Multi-cycle word adder controller that sits directly upstream of the registered 4-bit CLA stage (`final`) and also consumes its result. It accepts a wide operand pair over a valid/ready handshake and feeds it to the CLA one nibble at a time, LSB first, routing each nibble's carry-out into the next nibble's carry-in. It assembles the sum and presents it on a valid/ready output. This allows the existing 4-bit adder to serve 4·NIBBLES-bit additions without modification.

## Interface
- NIBBLES, default 4: number of 4-bit slices; word width W = 4·NIBBLES; legal range 1..16.
- clk  input  1  rising-edge clock, shared with the CLA stage.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  sequencer idle, will accept.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  word carry-in.
- cla_a  output  4  nibble of A to CLA.
- cla_b  output  4  nibble of B to CLA.
- cla_cin  output  1  carry-in to CLA.
- cla_s  input  4  registered CLA sum.
- cla_cout  input  1  registered CLA carry-out.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  assembled sum.
- out_cout  output  1  word carry-out.
- out_ovf  output  1  signed overflow; present only with SEQ_OVF_EN.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE. Nibble index k is a register, width ceil(log2(NIBBLES)), minimum 1.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a, in_b, and in_cin into the carry register. Set k=0 and go to DRIVE.
- DRIVE:
  - cla_a = A[4k+3:4k], cla_b = B[4k+3:4k], cla_cin = carry register.
  - Unconditionally go to SAMPLE.
- SAMPLE:
  - Hold the same cla_* values.
  - At the closing edge, write cla_s into sum[4k+3:4k] and cla_cout into the carry register.
  - If k = NIBBLES-1, go to DONE; otherwise set k=k+1 and go to DRIVE.
- DONE:
  - out_valid=1.
  - out_sum and out_cout (the final carry register) are held stable until out_ready=1, then go to IDLE.
- in_ready is 0 in every state except IDLE.
- No back-to-back overlap: a new operand is accepted no earlier than the cycle after the result handshake.
- cla_a, cla_b and cla_cin are 0 in IDLE and DONE.
- Arithmetic: {out_cout, out_sum} = in_a + in_b + in_cin, exact modulo 2^(W+1). Operands are unsigned unless overflow is configured in.
- The CLA stage has no reset. Its outputs are only sampled in SAMPLE, after a DRIVE cycle has loaded it, so power-up or stale contents are never used.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, cla_a=0, cla_b=0, cla_cin=0, k=0.
- Reset mid-operation:
  - The current transaction is aborted and discarded, and the FSM returns to IDLE immediately.
  - out_valid never asserts for the aborted operand pair.
- Let acceptance edge E0 be the edge where in_valid & in_ready are both high.
  - Each nibble takes 2 cycles.
  - out_valid rises after edge E0 + 2·NIBBLES, which is 8 edges for NIBBLES=4.
- CLA latency is fixed at one cycle:
  - The CLA registers the DRIVE inputs at the edge that ends DRIVE.
  - The sequencer captures that result at the edge that ends SAMPLE.
- Handshake outputs:
  - in_ready depends on state only.
  - out_valid depends on state only and never drops without out_ready.
  - Neither has any combinational path from in_valid or out_ready.
- If out_ready is already high when out_valid rises, the result is consumed in that one cycle and in_ready=1 in the next cycle.

## Configuration
- SEQ_OVF_EN defined:
  - Adds the out_ovf port.
  - out_ovf = (A[W-1] == B[W-1]) & (out_sum[W-1] != A[W-1]), i.e. two's-complement overflow.
  - It is registered together with the sum and is valid only while out_valid=1.
  - It resets to 0.
- SEQ_OVF_EN undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- NIBBLES=4, a=0x1234, b=0x4321, cin=0 -> out_sum=0x5555, out_cout=0; out_valid rises exactly 8 edges after acceptance.
- a=0xFFFF, b=0x0001, cin=0 -> out_sum=0x0000, out_cout=1. This proves the carry chains through all four nibbles; check cla_cin=1 in DRIVE for k=1..3.
- a=0x9999, b=0x9999, cin=1 -> out_sum=0x3333, out_cout=1. While busy, in_valid is held high with a second pair; check in_ready stays 0 and the second pair is accepted only after the result handshake.
- Hold out_ready=0 for 5 cycles after out_valid rises -> out_sum and out_cout stay stable and in_ready=0; out_ready=1 -> IDLE on the next cycle.
- Assert rst during the SAMPLE state of k=2 -> all outputs return to their reset values immediately and no out_valid follows. Then add a=0x0003, b=0x0004 -> out_sum=0x0007.
- With SEQ_OVF_EN: a=0x7FFF, b=0x0001 -> out_sum=0x8000, out_ovf=1. Then a=0x8000, b=0x8000 -> out_sum=0x0000, out_cout=1, out_ovf=1. Then a=0x0001, b=0xFFFF -> out_ovf=0.

Source files
------------

// File: rtl/cla_word_sequencer.sv
// Multi-cycle word adder controller: feeds a registered 4-bit CLA stage one nibble per
// two cycles, LSB first, and assembles the sum. Define SEQ_OVF_EN to add out_ovf.
module cla_word_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic [3:0]             cla_a,
    output logic [3:0]             cla_b,
    output logic                   cla_cin,
    input  logic [3:0]             cla_s,
    input  logic                   cla_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout
`ifdef SEQ_OVF_EN
    ,
    output logic                   out_ovf
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [KW+1:0]   nib_lsb;
    logic            last_nib;
`ifdef SEQ_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    assign nib_lsb  = {k_q, 2'b00};
    assign last_nib = (k_q == KW'(NIBBLES - 1));

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
`ifdef SEQ_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        cla_a     = 4'h0;
        cla_b     = 4'h0;
        cla_cin   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    k_d     = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cla_a   = a_q[nib_lsb +: 4];
                cla_b   = b_q[nib_lsb +: 4];
                cla_cin = carry_q;
                state_d = SAMPLE;
            end
            SAMPLE: begin
                // CLA output now reflects the inputs registered at the end of DRIVE
                cla_a               = a_q[nib_lsb +: 4];
                cla_b               = b_q[nib_lsb +: 4];
                cla_cin             = carry_q;
                sum_d[nib_lsb +: 4] = cla_s;
                carry_d             = cla_cout;
                if (last_nib) begin
                    state_d = DONE;
`ifdef SEQ_OVF_EN
                    ovf_d   = (a_q[W-1] == b_q[W-1]) & (cla_s[3] != a_q[W-1]);
`endif
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = carry_q;
`ifdef SEQ_OVF_EN
    assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Bench for cla_word_sequencer with a registered 4-bit CLA model; directed plus random adds
// checked against plain word arithmetic.
module tb_cla_word_sequencer;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready, in_cin = 1'b0;
    logic [W-1:0]  in_a = '0, in_b = '0, out_sum;
    logic [3:0]    cla_a, cla_b, cla_s;
    logic          cla_cin, cla_cout;
    logic          out_valid, out_ready = 1'b0, out_cout;
`ifdef SEQ_OVF_EN
    logic          out_ovf;
`endif

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Registered CLA stage, no reset
    always @(posedge clk) {cla_cout, cla_s} <= cla_a + cla_b + 5'(cla_cin);

    cla_word_sequencer #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
        .cla_s(cla_s), .cla_cout(cla_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
`ifdef SEQ_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_sum"}, 32'(out_sum), 32'd0);
        chk({tag, "_out_cout"}, 32'(out_cout), 32'd0);
        chk({tag, "_cla"}, 32'({cla_a, cla_b, cla_cin}), 32'd0);
`ifdef SEQ_OVF_EN
        chk({tag, "_out_ovf"}, 32'(out_ovf), 32'd0);
`endif
    endtask

    // One full transaction. Starts and ends at a negedge.
    // hold: cycles out_ready stays low after out_valid; pre_ready: out_ready high from the start.
    // keep: keep in_valid high with (na,nb) as the next pair while busy.
    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input int hold, input bit pre_ready,
                       input bit keep, input logic [W-1:0] na, input logic [W-1:0] nb);
        logic [W:0]   full;
        logic [W-1:0] lo_a, lo_b;
        logic [W:0]   lo_sum;
        logic         exp_carry, ovf_exp;
        int           n, k;
        full    = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        ovf_exp = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
        out_ready = pre_ready;
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (keep) begin in_a = na; in_b = nb; in_cin = 1'b0; end
        else in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            k = n / 2;
            lo_a = (k == 0) ? '0 : (a & ((W'(1) << (4*k)) - 1'b1));
            lo_b = (k == 0) ? '0 : (b & ((W'(1) << (4*k)) - 1'b1));
            lo_sum = {1'b0, lo_a} + {1'b0, lo_b} + (W+1)'(cin);
            exp_carry = lo_sum[4*k];
            if (n < 2*NIB) begin
                chk($sformatf("busy_ready_n%0d", n), 32'(in_ready), 32'd0);
                chk($sformatf("cla_a_n%0d", n), 32'(cla_a), 32'((a >> (4*k)) & 4'hF));
                chk($sformatf("cla_b_n%0d", n), 32'(cla_b), 32'((b >> (4*k)) & 4'hF));
                chk($sformatf("cla_cin_n%0d", n), 32'(cla_cin), 32'(exp_carry));
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(2*NIB));
        if (out_valid) begin
            chk("out_sum", 32'(out_sum), 32'(full[W-1:0]));
            chk("out_cout", 32'(out_cout), 32'(full[W]));
            chk("done_cla_zero", 32'({cla_a, cla_b, cla_cin}), 32'd0);
`ifdef SEQ_OVF_EN
            chk("out_ovf", 32'(ovf_exp), 32'(out_ovf));
`endif
            if (!pre_ready) begin
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_sum", 32'({out_cout, out_sum}), 32'(full));
                    chk("hold_in_ready", 32'(in_ready), 32'd0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            chk("post_in_ready", 32'(in_ready), 32'd1);
            chk("post_out_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("idle");

        txn(16'h1234, 16'h4321, 1'b0, 0, 1'b1, 1'b0, '0, '0);
        txn(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0, '0, '0);
        txn(16'h9999, 16'h9999, 1'b1, 1, 1'b0, 1'b1, 16'hABCD, 16'h1111);
        txn(16'hABCD, 16'h1111, 1'b0, 5, 1'b0, 1'b0, '0, '0);

        // Reset during SAMPLE of nibble 2 (five edges after acceptance)
        in_valid = 1'b1; in_a = 16'h5A5A; in_b = 16'hA5A5; in_cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        txn(16'h0003, 16'h0004, 1'b0, 0, 1'b0, 1'b0, '0, '0);

        txn(16'h7FFF, 16'h0001, 1'b0, 0, 1'b1, 1'b0, '0, '0);
        txn(16'h8000, 16'h8000, 1'b0, 0, 1'b1, 1'b0, '0, '0);
        txn(16'h0001, 16'hFFFF, 1'b0, 0, 1'b1, 1'b0, '0, '0);

        for (int t = 0; t < 25; t++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            txn(ra, rb, 1'($urandom_range(1)), int'($urandom_range(3)),
                1'($urandom_range(1)), 1'b0, '0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
